// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, base opcodes used by the decoder,
// and the fetch-stage state type.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// buffers the fetched instruction for the decoder; redirects discard wrong-path data.
//
// state | meaning
// FETCH | request outstanding (imem_req low only in the first cycle after reset)
// FLUSH | request outstanding, its data will be dropped, then fetch saved target
// HOLD  | instruction buffered, waiting for the decoder
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  redirect_saved;
  logic [31:0]  target;

  assign target = word_align(redirect_pc);

  // pc only changes when no request is in flight, so it doubles as the registered address
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_ADDR;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= NOP;
      instr_pc       <= RESET_ADDR;
      redirect_saved <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // nothing in flight yet, so a redirect can retarget directly
            imem_req <= 1'b1;
            if (redirect_valid) pc <= target;
          end else if (redirect_valid) begin
            if (imem_ready) begin
              pc <= target;
            end else begin
              redirect_saved <= target;
              state          <= FLUSH;
            end
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        FLUSH: begin
          if (imem_ready) begin
            pc    <= redirect_valid ? target : redirect_saved;
            state <= FETCH;
          end else if (redirect_valid) begin
            redirect_saved <= target;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= target;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset/wrap sequences,
// and randomized traffic checked against an instruction-stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOPW = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = JUNK;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_reset = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready = 1'b0;
  logic [31:0] w_rdata = JUNK;
  logic        w_valid;
  logic        w_ir = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_ir), .instr(w_instr), .instr_pc(w_ipc),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        ir;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic [31:0] rdata, input logic ir, input logic rv,
                     input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.ir = ir; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // {req, addr, valid, instr, instr_pc}, data fields only meaningful when valid
  function automatic logic [127:0] pack(input logic rq, input logic [31:0] ad, input logic vl,
                                        input logic [31:0] in, input logic [31:0] ip);
    return {30'b0, rq, ad, vl, vl ? in : 32'h0, vl ? ip : 32'h0};
  endfunction

  initial begin
    logic [31:0] exp_pc;
    int          deliveries;
    logic        p_req, p_rdy, p_valid, p_ir, p_rv;
    logic [31:0] p_addr, p_instr, p_ipc;
    bit          seen;

    // cycle inputs            rdy rdata        ir rv rpc          req addr        vl instr        ipc
    add(0, JUNK,          1, 0, 0,           1, 32'h0,      0, 0, 0);
    add(1, 32'h00100093,  1, 0, 0,           0, 32'h4,      1, 32'h00100093, 32'h0);
    add(0, JUNK,          1, 0, 0,           1, 32'h4,      0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, JUNK,        1, 0, 0,           1, 32'h4,      0, 0, 0);
    add(1, 32'h00200113,  1, 0, 0,           0, 32'h8,      1, 32'h00200113, 32'h4);
    add(0, JUNK,          1, 0, 0,           1, 32'h8,      0, 0, 0);
    add(1, 32'h00300193,  0, 0, 0,           0, 32'hC,      1, 32'h00300193, 32'h8);
    for (int i = 0; i < 5; i++)
      add(0, JUNK,        0, 0, 0,           0, 32'hC,      1, 32'h00300193, 32'h8);
    add(0, JUNK,          1, 0, 0,           1, 32'hC,      0, 0, 0);
    add(0, JUNK,          1, 1, 32'h100,     1, 32'hC,      0, 0, 0);
    add(0, JUNK,          1, 0, 0,           1, 32'hC,      0, 0, 0);
    add(1, JUNK,          1, 0, 0,           1, 32'h100,    0, 0, 0);
    add(1, 32'h00400213,  0, 0, 0,           0, 32'h104,    1, 32'h00400213, 32'h100);
    add(0, JUNK,          1, 1, 32'h203,     1, 32'h200,    0, 0, 0);
    add(1, 32'h00500293,  0, 0, 0,           0, 32'h204,    1, 32'h00500293, 32'h200);
    add(0, JUNK,          1, 0, 0,           1, 32'h204,    0, 0, 0);
    add(1, JUNK,          1, 1, 32'h304,     1, 32'h304,    0, 0, 0);
    add(0, JUNK,          1, 1, 32'h400,     1, 32'h304,    0, 0, 0);
    add(0, JUNK,          1, 1, 32'h501,     1, 32'h304,    0, 0, 0);
    add(1, JUNK,          1, 0, 0,           1, 32'h500,    0, 0, 0);
    add(1, 32'h00600313,  0, 0, 0,           0, 32'h504,    1, 32'h00600313, 32'h500);

    cyc();
    cyc();
    check("reset_state", {30'b0, imem_req, imem_addr, instr_valid, instr, instr_pc},
          {30'b0, 1'b0, 32'h0, 1'b0, NOPW, 32'h0});
    reset = 1'b0;

    foreach (vecs[i]) begin
      imem_ready     = vecs[i].rdy;
      imem_rdata     = vecs[i].rdata;
      instr_ready    = vecs[i].ir;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      cyc();
      check($sformatf("vec%0d", i), pack(imem_req, imem_addr, instr_valid, instr, instr_pc),
            pack(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_ipc));
    end

    // reset while holding, with a memory response on the bus that must be ignored
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = JUNK; instr_ready = 1'b0; redirect_valid = 1'b0;
    cyc();
    check("midop_reset", {30'b0, imem_req, imem_addr, instr_valid, instr, instr_pc},
          {30'b0, 1'b0, 32'h0, 1'b0, NOPW, 32'h0});
    imem_ready = 1'b0;
    reset = 1'b0;

    // randomized traffic: delivered stream must follow pc+4 and redirect targets
    exp_pc = 32'h0;
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom() & 32'h0000_3FFF;
      instr_ready    = ($urandom_range(0, 1) == 1);
      imem_ready     = imem_req && ($urandom_range(0, 1) == 1);
      imem_rdata     = imem_ready ? mem_word(imem_addr) : JUNK;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        check("rand_deliver", {64'h0, instr_pc, instr}, {64'h0, exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      p_req = imem_req; p_addr = imem_addr; p_rdy = imem_ready;
      p_valid = instr_valid; p_ir = instr_ready; p_rv = redirect_valid;
      p_instr = instr; p_ipc = instr_pc;
      cyc();
      if (p_req && !p_rdy)
        check("rand_req_stable", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, p_addr});
      if (p_valid && !p_ir && !p_rv)
        check("rand_hold_stable", {63'h0, instr_valid, instr, instr_pc}, {63'h0, 1'b1, p_instr, p_ipc});
    end
    check("rand_progress", {127'h0, deliveries > 100}, {127'h0, 1'b1});
    imem_ready = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;

    // PC wrap at the top of the address space
    check("wrap_reset", {64'h0, w_addr, w_ipc}, {64'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC});
    w_reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc();
      if (w_valid) seen = 1'b1;
      else begin
        w_ready = w_req;
        w_rdata = 32'h00700393;
      end
    end
    w_ready = 1'b0;
    check("wrap_fetch_timeout", {127'h0, seen}, {127'h0, 1'b1});
    check("wrap_hold", {31'h0, w_req, w_addr, w_instr, w_ipc},
          {31'h0, 1'b0, 32'h0, 32'h00700393, 32'hFFFF_FFFC});
    w_ir = 1'b1;
    cyc();
    check("wrap_next_req", {94'h0, w_req, w_valid, w_addr}, {94'h0, 1'b1, 1'b0, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
